// File: rtl/four_bit_ripple_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
// Optional build macro used by this block: RIPPLE_ADDER_OVERFLOW_EN.
package four_bit_ripple_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // {cout, sum} for the default operand width
  typedef logic [DEFAULT_WIDTH:0] result_t;

endpackage

// File: rtl/four_bit_ripple_adder_if.sv
// Operation/result bundle between an adder user (master) and the adder (slave).
// RIPPLE_ADDER_OVERFLOW_EN adds the registered signed-overflow flag.
interface four_bit_ripple_adder_if
  import four_bit_ripple_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  logic             overflow;

  modport master (output in_valid, a, b, cin, input out_valid, sum, cout, overflow);
  modport slave  (input in_valid, a, b, cin, output out_valid, sum, cout, overflow);
`else
  modport master (output in_valid, a, b, cin, input out_valid, sum, cout);
  modport slave  (input in_valid, a, b, cin, output out_valid, sum, cout);
`endif
endinterface

// File: rtl/four_bit_ripple_adder_full_adder_cell.sv
// Single-bit full-adder cell; one instance per bit of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/four_bit_ripple_adder.sv
// Registered N-bit ripple-carry adder built from full_adder_cell instances.
// Define RIPPLE_ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module four_bit_ripple_adder
  import four_bit_ripple_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  four_bit_ripple_adder_if.slave  bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  logic             overflow_q, overflow_d;
`endif

  assign carry[0] = bus.cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      full_adder_cell u_cell (
        .a  (bus.a[gi]),
        .b  (bus.b[gi]),
        .ci (carry[gi]),
        .s  (sum_comb[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  // Result registers hold their value across idle cycles; only out_valid drops.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = bus.in_valid;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    overflow_d  = overflow_q;
`endif
    if (bus.in_valid) begin
      sum_d  = sum_comb;
      cout_d = carry[WIDTH];
`ifdef RIPPLE_ADDER_OVERFLOW_EN
      overflow_d = carry[WIDTH] ^ carry[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  assign bus.overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_four_bit_ripple_adder.sv
// Scoreboard bench for four_bit_ripple_adder: directed vectors with hand-computed results.
// Exercises the overflow flag and an exhaustive sweep when RIPPLE_ADDER_OVERFLOW_EN is defined.
module tb_four_bit_ripple_adder;
  import four_bit_ripple_adder_pkg::*;

  typedef struct {
    result_t res;
    logic    ovf;
    int      due;
    string   name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  exp_t sb_q[$];

  four_bit_ripple_adder_if #(.WIDTH(4)) bus ();

  four_bit_ripple_adder #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Monitor: pops one expectation for each presented result.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got sum=%b cout=%b, required no output", bus.sum, bus.cout);
      end else begin
        e = sb_q.pop_front();
        if ({bus.cout, bus.sum} !== e.res || e.due != cyc) begin
          fails++;
          $display("FAIL %s: got cout=%b sum=%b at cycle %0d, required cout=%b sum=%b at cycle %0d",
                   e.name, bus.cout, bus.sum, cyc, e.res[4], e.res[3:0], e.due);
        end
`ifdef RIPPLE_ADDER_OVERFLOW_EN
        tests++;
        if (bus.overflow !== e.ovf) begin
          fails++;
          $display("FAIL %s_ovf: got overflow=%b, required %b", e.name, bus.overflow, e.ovf);
        end
`endif
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      tests++;
      fails++;
      e = sb_q.pop_front();
      $display("FAIL %s_missing: got out_valid=%b, required 1", e.name, bus.out_valid);
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  // Drive one cycle of stimulus from the falling edge; outputs are valid at the next falling edge.
  task automatic issue(input string name, input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic v, input logic r,
                       input logic [3:0] es, input logic ec, input logic eo);
    exp_t e;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    bus.in_valid = v;
    rst          = r;
    if (v && !r) begin
      e.res  = {ec, es};
      e.ovf  = eo;
      e.due  = cyc + 1;
      e.name = name;
      sb_q.push_back(e);
    end
    $display("[TB] cyc=%0d %s a=%b b=%b cin=%b in_valid=%b rst=%b", cyc, name, a, b, ci, v, r);
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    @(negedge clk);

    // Reset has priority over valid operations
    for (int i = 0; i < 2; i++) begin
      issue("rst_hold", 4'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1, 4'b0, 1'b0, 1'b0);
      check("rst_out_valid", {7'b0, bus.out_valid}, 8'd0);
      check("rst_sum", {4'b0, bus.sum}, 8'd0);
      check("rst_cout", {7'b0, bus.cout}, 8'd0);
    end
    for (int i = 0; i < 2; i++) begin
      issue("idle_after_rst", 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
      check("idle_out_valid", {7'b0, bus.out_valid}, 8'd0);
      check("idle_sum", {4'b0, bus.sum}, 8'd0);
      check("idle_cout", {7'b0, bus.cout}, 8'd0);
    end

    // Back-to-back basic adds, cin=0
    issue("add_0_0",     4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    issue("add_1_2",     4'b0001, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0);
    issue("add_4_2",     4'b0100, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
    issue("add_a_5",     4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
    issue("add_f_0",     4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
    issue("add_0_f",     4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
    issue("add_6_2",     4'b0110, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);
    // Carry-in and full ripple
    issue("add_e_6_c1",  4'b1110, 4'b0110, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0);
    issue("add_7_7_c1",  4'b0111, 4'b0111, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1);
    issue("add_f_1",     4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    issue("add_f_f_c1",  4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);

    // Valid gating: result must hold while out_valid drops
    issue("gate_load",   4'b0001, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0);
    issue("gate_idle",   4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("gate_out_valid", {7'b0, bus.out_valid}, 8'd0);
    check("gate_sum", {4'b0, bus.sum}, 8'b0000_0011);
    check("gate_cout", {7'b0, bus.cout}, 8'd0);

    // Reset in the middle of a valid stream discards the in-flight operation
    issue("stream_a",    4'b0101, 4'b0101, 1'b0, 1'b1, 1'b0, 4'b1010, 1'b0, 1'b1);
    issue("stream_rst",  4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("midrst_out_valid", {7'b0, bus.out_valid}, 8'd0);
    check("midrst_sum", {4'b0, bus.sum}, 8'd0);
    check("midrst_cout", {7'b0, bus.cout}, 8'd0);
    issue("stream_b",    4'b0011, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);

`ifdef RIPPLE_ADDER_OVERFLOW_EN
    issue("ovf_7_1",     4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);
    issue("ovf_8_8",     4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    issue("ovf_clear",   4'b0010, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0);
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [4:0] ref_sum;
          logic       ref_ovf;
          ref_sum = 5'(ia) + 5'(ib) + 5'(ic);
          ref_ovf = (ia[3] == ib[3]) && (ref_sum[3] != ia[3]);
          issue("exhaustive", 4'(ia), 4'(ib), 1'(ic), 1'b1, 1'b0, ref_sum[3:0], ref_sum[4], ref_ovf);
        end
      end
    end
`endif

    issue("drain", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    check("scoreboard_empty", 8'(sb_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/four_bit_ripple_adder.md
Name:
four_bit_ripple_adder

Overview:
- Structural N-bit (default 4) ripple-carry adder computing a + b + cin, built from a chain of single-bit full-adder cells.
- Result (sum, cout) is captured in an output register, giving one clock of latency.
- Used as a small arithmetic leaf block wherever a registered narrow add with carry-in/carry-out is needed.

Parameters:
- WIDTH, 4, operand and sum width in bits (must be >= 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b/cin hold a valid operation this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout hold the result of an accepted operation.
- sum  output  WIDTH  registered sum bits [WIDTH-1:0].
- cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset: on a rising clk edge with rst=1, sum=0, cout=0, out_valid=0 (overflow=0 if enabled). rst has priority over in_valid.
- Datapath is purely combinational and structural: bit i is a full-adder cell fed by a[i], b[i] and carry c[i], with c[0]=cin and cout=c[WIDTH].
  - Cell equations: s = a^b^c, co = (a&b)|(c&(a^b)).
- No behavioural "+" operator in the datapath.
- Full result {cout,sum} = a + b + cin, exact, in WIDTH+1 bits. No saturation; wrap-around appears only as cout=1.
- Latency: exactly 1 cycle. If in_valid=1 at edge k, then after edge k sum/cout hold that result and out_valid=1.
- If in_valid=0 at an edge: sum/cout keep their previous values and out_valid goes 0.
- No backpressure. A new operation is accepted every cycle; back-to-back operations produce back-to-back results.
- Boundaries:
  - all-ones + all-ones + 1 gives sum = all-ones, cout = 1.
  - 0 + 0 + 0 gives sum = 0, cout = 0.
  - rst asserted mid-stream discards the in-flight result; out_valid=0 on the following cycle.
- Inputs may change arbitrarily between edges; only values at the rising edge matter.

Optional Feature:
- Macro RIPPLE_ADDER_OVERFLOW_EN.
- When defined:
  - Extra output port overflow (1 bit, registered alongside sum) = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow.
  - Reset value 0; holds its value when in_valid=0, like sum.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package four_bit_ripple_adder_pkg holds:
  - constant DEFAULT_WIDTH = 4;
  - typedef for the WIDTH+1-bit result {cout,sum}.
- One sub-module full_adder_cell (inputs a, b, ci; outputs s, co), instantiated WIDTH times via generate.
- The top level holds the carry chain and the output register.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs and in_valid=1 -> sum=0000, cout=0, out_valid=0. Release rst, hold in_valid=0 -> outputs stay 0.
- Basic adds with cin=0, in_valid=1, one per cycle: 0000+0000, 0001+0010, 0100+0010, 1010+0101, 1111+0000, 0000+1111, 0110+0010 -> next-cycle sums 0000, 0011, 0110, 1111, 1111, 1111, 1000, all with cout=0 and out_valid=1.
- Carry-in with carry-out: 1110+0110 with cin=1 -> sum=0101, cout=1. 0111+0111 with cin=1 -> sum=1111, cout=0.
- Full ripple: 1111+0001 with cin=0 -> sum=0000, cout=1. 1111+1111 with cin=1 -> sum=1111, cout=1.
- Valid gating and mid-stream reset:
  - Result 0011 registered, then in_valid=0 with a=1111 -> sum stays 0011, out_valid=0.
  - rst pulsed during a valid stream -> next cycle out_valid=0 and sum=0000.
- With RIPPLE_ADDER_OVERFLOW_EN defined: 0111+0001 with cin=0 -> sum=1000, overflow=1, cout=0. 1000+1000 -> sum=0000, overflow=1, cout=1. Also run exhaustive 4-bit plus cin comparison against a reference add.
